// File: rtl/us_pkg.sv
// Shared state encoding, widths and channel-selection helper for the
// ultrasonic scan scheduler.
package us_pkg;

  localparam int US_W = 16;
  localparam int ID_W = 3;

  typedef logic [2:0] us_state_t;

  localparam us_state_t IDLE      = 3'd0;
  localparam us_state_t TRIG      = 3'd1;
  localparam us_state_t WAIT_RISE = 3'd2;
  localparam us_state_t MEASURE   = 3'd3;
  localparam us_state_t GUARD     = 3'd4;

  // First set bit of mask at or after start, wrapping within n channels.
  function automatic logic [ID_W-1:0] next_set(input logic [7:0]      mask,
                                               input logic [ID_W-1:0] start,
                                               input int              n);
    logic [ID_W-1:0] found;
    logic            hit;
    int              idx;
    found = start;
    hit   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = int'(start) + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !hit && mask[idx[2:0]]) begin
        hit   = 1'b1;
        found = idx[ID_W-1:0];
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLK_PER_US clocks, restarted
// by clr so every scheduler state begins on a fresh microsecond boundary.
module us_tick_gen #(
  parameter int CLK_PER_US = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/us_scan_scheduler.sv
// Round-robin trigger/echo scheduler for HC-SR04-class sensors sharing one
// acoustic slot; publishes one width/timeout record per measurement.
module us_scan_scheduler
  import us_pkg::*;
#(
  parameter int NUM_SENSORS = 4,
  parameter int CLK_PER_US  = 50,
  parameter int TRIG_US     = 10,
  parameter int RISE_TO_US  = 30000,
  parameter int MAX_ECHO_US = 25000,
  parameter int GUARD_US    = 60000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Enable,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  input  logic [NUM_SENSORS-1:0] Echo,
  output logic [NUM_SENSORS-1:0] Trigger,
  output logic                   busy,
  output logic                   meas_valid,
  output logic [ID_W-1:0]        meas_id,
  output logic [US_W-1:0]        meas_us,
  output logic                   meas_timeout
);

  // Exits fire on the tick that would carry the counter onto the limit,
  // so each state lasts exactly limit * CLK_PER_US cycles.
  localparam logic [US_W-1:0] C_TRIG_LAST  = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0] C_RISE_LAST  = US_W'(RISE_TO_US - 1);
  localparam logic [US_W-1:0] C_MAX_LAST   = US_W'(MAX_ECHO_US - 1);
  localparam logic [US_W-1:0] C_MAX        = US_W'(MAX_ECHO_US);
  localparam logic [US_W-1:0] C_GUARD_LAST = US_W'(GUARD_US - 1);
  localparam logic [ID_W-1:0] C_LAST_ID    = ID_W'(NUM_SENSORS - 1);

  logic [NUM_SENSORS-1:0] r_echo_m, r_echo_s, r_echo_d, r_trigger, w_trig_next;
  us_state_t              r_state, w_next;
  logic [ID_W-1:0]        r_sel, w_next_sel, r_ptr, w_next_ptr, w_sel_inc;
  logic [US_W-1:0]        r_us, w_emit_us;
  logic [7:0]             w_mask8;
  logic                   w_tick, w_chg, w_emit, w_emit_to;
  logic                   w_es, w_ed, w_rise, w_fall, w_any;
  logic                   r_meas_valid, r_meas_timeout;
  logic [ID_W-1:0]        r_meas_id;
  logic [US_W-1:0]        r_meas_us;

  us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_chg),
    .tick (w_tick)
  );

  always_comb begin
    w_mask8 = '0;
    w_mask8[NUM_SENSORS-1:0] = sensor_mask;
  end

  always_comb begin
    w_es = 1'b0;
    w_ed = 1'b0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (r_sel == ID_W'(i)) begin
        w_es = r_echo_s[i];
        w_ed = r_echo_d[i];
      end
    end
  end

  assign w_rise    = w_es & ~w_ed;
  assign w_fall    = ~w_es & w_ed;
  assign w_any     = |sensor_mask;
  assign w_sel_inc = (r_sel == C_LAST_ID) ? '0 : r_sel + 1'b1;

  always_comb begin
    w_next     = r_state;
    w_next_sel = r_sel;
    w_next_ptr = r_ptr;
    w_emit     = 1'b0;
    w_emit_us  = '0;
    w_emit_to  = 1'b0;
    case (r_state)
      IDLE: begin
        if (Enable && w_any) begin
          w_next     = TRIG;
          w_next_sel = next_set(w_mask8, r_ptr, NUM_SENSORS);
        end
      end
      TRIG: begin
        if (w_tick && r_us >= C_TRIG_LAST) w_next = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (w_rise) begin
          w_next = MEASURE;
        end else if (w_tick && r_us >= C_RISE_LAST) begin
          w_next    = GUARD;
          w_emit    = 1'b1;
          w_emit_to = 1'b1;
        end
      end
      MEASURE: begin
        if (w_fall) begin
          w_next    = GUARD;
          w_emit    = 1'b1;
          w_emit_us = r_us;
        end else if (w_tick && r_us >= C_MAX_LAST) begin
          w_next    = GUARD;
          w_emit    = 1'b1;
          w_emit_us = C_MAX;
          w_emit_to = 1'b1;
        end
      end
      GUARD: begin
        if (w_tick && r_us >= C_GUARD_LAST) begin
          w_next_ptr = w_sel_inc;
          if (Enable && w_any) begin
            w_next     = TRIG;
            w_next_sel = next_set(w_mask8, w_sel_inc, NUM_SENSORS);
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_chg = (w_next != r_state);

  // Trigger is registered from the next state so it never glitches on a sel change.
  always_comb begin
    w_trig_next = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      w_trig_next[i] = (w_next == TRIG) && (w_next_sel == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_m       <= '0;
      r_echo_s       <= '0;
      r_echo_d       <= '0;
      r_state        <= IDLE;
      r_sel          <= '0;
      r_ptr          <= '0;
      r_us           <= '0;
      r_trigger      <= '0;
      r_meas_valid   <= 1'b0;
      r_meas_id      <= '0;
      r_meas_us      <= '0;
      r_meas_timeout <= 1'b0;
    end else begin
      r_echo_m     <= Echo;
      r_echo_s     <= r_echo_m;
      r_echo_d     <= r_echo_s;
      r_state      <= w_next;
      r_sel        <= w_next_sel;
      r_ptr        <= w_next_ptr;
      r_trigger    <= w_trig_next;
      r_meas_valid <= w_emit;
      if (w_chg) begin
        r_us <= '0;
      end else if (w_tick && r_us != '1) begin
        r_us <= r_us + 1'b1;
      end
      if (w_emit) begin
        r_meas_id      <= r_sel;
        r_meas_us      <= w_emit_us;
        r_meas_timeout <= w_emit_to;
      end
    end
  end

  assign Trigger      = r_trigger;
  assign busy         = (r_state != IDLE);
  assign meas_valid   = r_meas_valid;
  assign meas_id      = r_meas_id;
  assign meas_us      = r_meas_us;
  assign meas_timeout = r_meas_timeout;

endmodule

// File: doc/us_scan_scheduler.md
# us_scan_scheduler

Round-robin scheduler for several HC-SR04-class ultrasonic sensors that share one measurement slot, so only one sensor is active at a time and there is no acoustic crosstalk. For each enabled sensor in turn it issues the trigger pulse, times the echo in microseconds, and handles missing or stuck echoes with timeouts. It enforces a guard interval before moving to the next sensor. It sits between the raw sensor pins and the event/threshold logic, and publishes one result record per measurement.

## Interface
- NUM_SENSORS, 4, number of sensor channels (2..8)
- CLK_PER_US, 50, clk cycles per microsecond (50 MHz board clock)
- TRIG_US, 10, trigger pulse width in µs
- RISE_TO_US, 30000, maximum wait from trigger end to echo rise, in µs
- MAX_ECHO_US, 25000, echo width at which the measurement saturates, in µs
- GUARD_US, 60000, quiet time after each measurement, in µs
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  asynchronous active-low reset
- Enable  in  1  scan enable; high = keep scanning
- sensor_mask  in  NUM_SENSORS  1 = channel takes part in the scan; sampled when a channel is selected
- Echo  in  NUM_SENSORS  raw asynchronous echo pins
- Trigger  out  NUM_SENSORS  trigger pins, at most one high at any time
- busy  out  1  high in every state except IDLE
- meas_valid  out  1  one-cycle pulse; result fields are valid in that cycle
- meas_id  out  3  channel index of the result
- meas_us  out  16  echo width in µs, saturating
- meas_timeout  out  1  result is a timeout (no rise, or echo reached saturation)

## Operation
- Echo inputs pass through a 2-flop synchronizer to give echo_s. The edge detector compares echo_s with a registered copy of itself.
- A µs prescaler counts 0..CLK_PER_US-1 and emits a one-cycle tick. It restarts at 0 in the cycle after every state change, so all state durations are exact multiples of CLK_PER_US cycles. A 16-bit µs counter clears on every state change and increments on each tick.
- The state machine has five states: IDLE, TRIG, WAIT_RISE, MEASURE, GUARD.
- IDLE:
  - If Enable is high and sensor_mask is nonzero, select the channel `sel` and go to TRIG.
  - Channel selection: the first set mask bit at or after `ptr`, wrapping around.
  - If the mask is all zero, stay in IDLE.
- TRIG:
  - Trigger[sel] is high.
  - Leave for WAIT_RISE when the µs counter reaches TRIG_US.
- WAIT_RISE:
  - A rising edge on echo_s[sel] moves to MEASURE. An echo that is already high on entry is ignored until it goes low and rises again.
  - If the µs counter reaches RISE_TO_US first, emit a result with meas_timeout=1 and meas_us=0, then go to GUARD.
- MEASURE:
  - On a falling edge of echo_s[sel], emit a result with meas_us equal to the µs counter and meas_timeout=0, then go to GUARD.
  - If the µs counter reaches MAX_ECHO_US first, emit a result with meas_us=MAX_ECHO_US and meas_timeout=1, then go to GUARD.
- GUARD:
  - When the µs counter reaches GUARD_US, set ptr=sel+1 (wrapping modulo NUM_SENSORS).
  - Then, if Enable is high and the mask is nonzero, select the next channel and go to TRIG; otherwise go to IDLE.
- Enable going low in the middle of a scan does not abort it. The current channel runs through GUARD and then the block returns to IDLE.
- Echo activity on channels other than sel is ignored.

## Timing
- Reset values:
  - Trigger=0, busy=0, meas_valid=0, meas_id=0, meas_us=0, meas_timeout=0.
  - State=IDLE, ptr=0, prescaler=0, µs counter=0.
- Latency from Enable high in IDLE to Trigger high is 1 cycle.
- Trigger width is exactly TRIG_US*CLK_PER_US cycles, with no glitch when sel changes.
- An echo edge on the pin produces the corresponding state change 3 cycles later (2-flop synchronizer plus edge register).
- meas_valid is registered and is asserted in the first cycle of GUARD. The result fields hold their values until the next meas_valid.
- The reported width meas_us is the echo width measured in µs ticks, which is accurate to within ±1 µs.
- The µs counter saturates at 0xFFFF and never wraps.
- Asserting rst_n low in any state immediately drops Trigger and returns the block to the reset state.

## Structure
- A shared package `us_pkg` holds the state enum (IDLE, TRIG, WAIT_RISE, MEASURE, GUARD), the constants US_W=16 and ID_W=3, and a function that finds the next set mask bit with wrap-around.
- One sub-module, `us_tick_gen`, contains the prescaler. Its ports are clk, rst_n, clr, and tick.
- The synchronizer, FSM, µs counter and result registers live in `us_scan_scheduler`.

## Test plan
All scenarios use CLK_PER_US=4, TRIG_US=10, RISE_TO_US=20, MAX_ECHO_US=100, GUARD_US=50, NUM_SENSORS=4.
- Basic measurement: mask=4'b0001; Enable high; hold Echo[0] high for 58 µs (232 cycles) starting 5 µs after trigger end. Expect Trigger[0] high for 40 cycles, then meas_valid with id=0, us=58±1, timeout=0.
- Round robin: mask=4'b1011; each echo 20 µs wide. Expect meas_id sequence 0,1,3,0. Exactly one Trigger bit is high at a time, and there are 50 µs between the end of one measurement and the next Trigger.
- No echo: Echo stays low. Expect meas_valid 20 µs after trigger end with us=0, timeout=1, followed by the guard interval and the next channel.
- Stuck-high echo: Echo[0] is held high from before TRIG. Expect no MEASURE and a rise timeout (us=0, timeout=1). With Echo held high for 150 µs after a clean rise, expect us=100, timeout=1.
- Enable dropped during MEASURE: the current result is still emitted, GUARD completes, then the block enters IDLE with busy=0 and no further Trigger.
- Reset during TRIG: pulse rst_n low for 1 cycle. Trigger=0 immediately and all outputs return to their reset values. With Enable still high, the scan restarts at channel 0.
